// File: rtl/pkt_tx_streamer.sv
// ---------------------------------------------------------------------------
// pkt_tx_streamer
//
// Takes a complete 54-byte Ethernet+IPv4+TCP header from the packet builder,
// computes the IPv4 header checksum and inserts it, then streams the header
// out as 14 32-bit Avalon-ST words (the last word carries 2 valid bytes).
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset
//   hdr_valid  : header available from the builder
//   hdr_ready  : streamer can accept a header (high only while idle)
//   hdr_data   : 432-bit header, byte 0 in bits [431:424]
//   tx_valid   : output word valid
//   tx_ready   : sink accepts the current word
//   tx_data    : output word, first byte on the wire in [31:24]
//   tx_sop     : first word of the packet
//   tx_eop     : last word of the packet
//   tx_empty   : unused low-order bytes of the eop word
//   pkt_count  : number of packets fully sent, wrapping
// ---------------------------------------------------------------------------
module pkt_tx_streamer #(
    parameter int PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hdr_valid,
    output logic                 hdr_ready,
    input  logic [431:0]         hdr_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [31:0]          tx_data,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic [1:0]           tx_empty,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        SEND
    } state_t;

    localparam logic [3:0] LAST_CSUM_STEP = 4'd9;
    localparam logic [3:0] LAST_WORD      = 4'd13;

    state_t         state;
    state_t         state_n;
    logic [431:0]   hdr_buf;
    logic [447:0]   frame;
    logic [16:0]    acc;
    logic [16:0]    acc_n;
    logic [15:0]    ip_word;
    logic [3:0]     csum_cnt;
    logic [3:0]     word_idx;
    logic           hdr_accept;
    logic           csum_last;
    logic           word_accept;

    // Fold the end-around carry of a 17-bit partial sum back into 16 bits.
    // The partial sum never exceeds 0x1FFFE, so the fold cannot carry again.
    function automatic logic [15:0] csum_fold(input logic [16:0] s);
        return s[15:0] + {15'd0, s[16]};
    endfunction

    assign hdr_accept  = (state == IDLE) && hdr_valid;
    assign csum_last   = (state == CSUM) && (csum_cnt == LAST_CSUM_STEP);
    assign word_accept = (state == SEND) && tx_ready;

    // The last word only carries bytes 52,53; pad the buffer with two zero bytes.
    assign frame = {hdr_buf, 16'h0000};

    // IPv4 header word k spans bytes 14+2k..15+2k; the checksum field (k=5)
    // is summed as zero so a stale input value cannot leak into the result.
    always_comb begin
        ip_word = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            if (csum_cnt == 4'(k) && k != 5) begin
                ip_word = hdr_buf[319 - 16*k -: 16];
            end
        end
    end

    assign acc_n = {1'b0, csum_fold(acc)} + {1'b0, ip_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        hdr_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 32'h0000_0000;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        tx_empty  = 2'd0;
        unique case (state)
            IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid) begin
                    state_n = CSUM;
                end
            end
            CSUM: begin
                if (csum_cnt == LAST_CSUM_STEP) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                for (int i = 0; i < 14; i++) begin
                    if (word_idx == 4'(i)) begin
                        tx_data = frame[447 - 32*i -: 32];
                    end
                end
                tx_sop = (word_idx == 4'd0);
                tx_eop = (word_idx == LAST_WORD);
                if (word_idx == LAST_WORD) begin
                    tx_empty = 2'd2;
                end
                if (tx_ready && word_idx == LAST_WORD) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state: checksum accumulator, step/word counters, packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 17'd0;
            csum_cnt  <= 4'd0;
            word_idx  <= 4'd0;
            pkt_count <= '0;
        end else begin
            if (hdr_accept) begin
                acc      <= 17'd0;
                csum_cnt <= 4'd0;
                word_idx <= 4'd0;
            end else if (state == CSUM) begin
                acc      <= acc_n;
                csum_cnt <= csum_last ? 4'd0 : csum_cnt + 4'd1;
            end else if (word_accept) begin
                if (word_idx == LAST_WORD) begin
                    word_idx  <= 4'd0;
                    pkt_count <= pkt_count + {{(PKT_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    word_idx <= word_idx + 4'd1;
                end
            end
        end
    end

    // Header buffer is pure data and needs no reset: nothing reads it
    // outside CSUM/SEND, and both are only entered through a fresh capture.
    always_ff @(posedge clk) begin
        if (hdr_accept) begin
            hdr_buf <= hdr_data;
        end else if (csum_last) begin
            hdr_buf[239:224] <= ~csum_fold(acc_n);
        end
    end

endmodule

// File: tb/tb_pkt_tx_streamer.sv
// ---------------------------------------------------------------------------
// tb_pkt_tx_streamer
//
// Directed bench for pkt_tx_streamer: known IPv4 headers with hand-computed
// checksums, continuous and stalled sinks, reset in mid-packet, and packet
// counter wrap (counter width reduced so the wrap is reached quickly).
// ---------------------------------------------------------------------------
module tb_pkt_tx_streamer;

    localparam int CW = 3;

    localparam logic [111:0] ETH = 112'h0011_2233_4455_6677_8899_aabb_0800;
    localparam logic [159:0] TCP = 160'h1234_5678_0000_0001_0000_0000_5010_ffff_0000_0000;

    // IPv4 headers and their hand-computed checksums.
    localparam logic [159:0] IP_A  = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
    localparam logic [159:0] IP_AF = 160'h4500_0073_0000_4000_4011_ffff_c0a8_0001_c0a8_00c7;
    localparam logic [159:0] IP_Z  = 160'h4500_0073_0000_4000_4011_1234_c0a8_0001_c0a8_b928;
    localparam logic [159:0] IP_B  = 160'h4500_003c_1c46_4000_4006_0000_ac10_0a63_ac10_0a0c;
    localparam logic [15:0]  CS_A  = 16'hb861;
    localparam logic [15:0]  CS_Z  = 16'h0000;
    localparam logic [15:0]  CS_B  = 16'hb1e6;

    logic          clk;
    logic          rst_n;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [431:0]  hdr_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [31:0]   tx_data;
    logic          tx_sop;
    logic          tx_eop;
    logic [1:0]    tx_empty;
    logic [CW-1:0] pkt_count;

    int            n_total;
    int            n_bad;
    logic [CW-1:0] exp_cnt;

    pkt_tx_streamer #(.PKT_CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .hdr_data  (hdr_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_empty  (tx_empty),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: sink always ready; mode 1: ready pattern 1,0,0,1 repeating.
    // abort_at >= 0 pulses rst_n low while that word is on the bus.
    task automatic run_pkt(input logic [159:0] ip, input logic [15:0] csum,
                           input int mode, input int abort_at);
        logic [159:0] ip_exp;
        logic [447:0] frame;
        logic [31:0]  w;
        int           idx;
        int           cyc;
        bit           aborted;
        ip_exp        = ip;
        ip_exp[79:64] = csum;
        frame         = {ETH, ip_exp, TCP, 16'h0000};
        aborted       = 1'b0;

        @(negedge clk);
        chk("hdr_ready_idle", 32'(hdr_ready), 32'd1);
        hdr_data  = {ETH, ip, TCP};
        hdr_valid = 1'b1;
        @(posedge clk);

        // Ten cycles of checksum work with nothing on the output bus.
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) begin
                hdr_valid = 1'b0;
                hdr_data  = ~hdr_data;
            end
            chk("csum_tx_valid", 32'(tx_valid), 32'd0);
            chk("csum_hdr_ready", 32'(hdr_ready), 32'd0);
        end

        idx = 0;
        cyc = 0;
        while (idx < 14 && cyc < 100 && !aborted) begin
            @(negedge clk);
            tx_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            w = frame[447 - 32*idx -: 32];
            chk("tx_valid", 32'(tx_valid), 32'd1);
            chk("tx_data", tx_data, w);
            chk("tx_sop", 32'(tx_sop), (idx == 0) ? 32'd1 : 32'd0);
            chk("tx_eop", 32'(tx_eop), (idx == 13) ? 32'd1 : 32'd0);
            chk("tx_empty", 32'(tx_empty), (idx == 13) ? 32'd2 : 32'd0);
            chk("send_hdr_ready", 32'(hdr_ready), 32'd0);
            if (idx == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_tx_valid", 32'(tx_valid), 32'd0);
                chk("rst_tx_data", tx_data, 32'd0);
                chk("rst_tx_sop", 32'(tx_sop), 32'd0);
                chk("rst_hdr_ready", 32'(hdr_ready), 32'd1);
                chk("rst_pkt_count", 32'(pkt_count), 32'd0);
                @(negedge clk);
                rst_n   = 1'b1;
                exp_cnt = '0;
                aborted = 1'b1;
            end else begin
                if (tx_valid && tx_ready) idx++;
                cyc++;
            end
        end

        if (!aborted) begin
            chk("words_sent", 32'(idx), 32'd14);
            if (mode == 0) chk("burst_cycles", 32'(cyc), 32'd14);
            exp_cnt = exp_cnt + 1'b1;
            @(negedge clk);
            chk("end_tx_valid", 32'(tx_valid), 32'd0);
            chk("end_hdr_ready", 32'(hdr_ready), 32'd1);
            chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        hdr_valid = 1'b0;
        hdr_data  = '0;
        tx_ready  = 1'b0;

        #3;
        chk("reset_hdr_ready", 32'(hdr_ready), 32'd1);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", tx_data, 32'd0);
        chk("reset_flags", {29'd0, tx_sop, tx_eop, 1'b0} | 32'(tx_empty), 32'd0);
        chk("reset_pkt_count", 32'(pkt_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_pkt(IP_A,  CS_A, 0, -1);   // reference header, word 6 = b861_c0a8
        run_pkt(IP_AF, CS_A, 0, -1);   // stale checksum field ignored
        run_pkt(IP_Z,  CS_Z, 0, -1);   // sum 0xFFFF -> checksum 0x0000
        run_pkt(IP_B,  CS_B, 1, -1);   // stalled sink
        run_pkt(IP_A,  CS_A, 0, 7);    // reset during word 7
        run_pkt(IP_A,  CS_A, 0, -1);   // full packet after reset

        for (int p = 0; p < 6; p++) run_pkt(IP_B, CS_B, 0, -1);
        chk("cnt_at_max", 32'(pkt_count), 32'd7);
        run_pkt(IP_A, CS_A, 0, -1);
        chk("cnt_wrapped", 32'(pkt_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
